// File: rtl/lc3b_types.sv
// Shared LC-3b types; holds the write-merge buffer state encoding.
package lc3b_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        VALID = 2'd1,
        DRAIN = 2'd2
    } wmb_state_t;

endpackage

// File: rtl/line_byte_mask.sv
// Maps a word store (address + per-lane enable) onto a line-wide byte mask.
module line_byte_mask #(
    parameter int LINE_BYTES = 16,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 16
) (
    input  logic [ADDR_W-1:0]     address,
    input  logic [WORD_BYTES-1:0] byte_enable,
    output logic [LINE_BYTES-1:0] byte_mask
);
    localparam int WORD_OFF = $clog2(WORD_BYTES);
    localparam int LINE_OFF = $clog2(LINE_BYTES);
    localparam int SLOT_W   = LINE_OFF - WORD_OFF;

    logic [SLOT_W-1:0] slot;
    logic              unused_address;

    assign slot           = address[LINE_OFF-1:WORD_OFF];
    // Tag and in-word offset bits play no part in the mask.
    assign unused_address = ^address;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_byte
            assign byte_mask[gi] = (slot == SLOT_W'(gi / WORD_BYTES))
                                   && byte_enable[gi % WORD_BYTES];
        end
    endgenerate

endmodule

// File: rtl/write_merge_buffer.sv
// Single-line write-combining buffer draining masked line writes to memory.
// Optional store-to-load forwarding port enabled by defining WMB_FWD_EN.
module write_merge_buffer
    import lc3b_types::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_write,
    input  logic [ADDR_W-1:0]       cpu_address,
    input  logic [8*WORD_BYTES-1:0] cpu_wdata,
    input  logic [WORD_BYTES-1:0]   cpu_byte_enable,
    output logic                    cpu_resp,
    input  logic                    flush,
    output logic                    idle,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    output logic [LINE_BYTES-1:0]   mem_byte_mask,
    input  logic                    mem_resp
`ifdef WMB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]       rd_address,
    output logic                    rd_hit,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic [WORD_BYTES-1:0]   rd_mask
`endif
);
    localparam int LINE_OFF = $clog2(LINE_BYTES);
    localparam int TAG_W    = ADDR_W - LINE_OFF;

    wmb_state_t            state_reg;
    logic [7:0]            data_reg [LINE_BYTES];
    logic [LINE_BYTES-1:0] mask_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic                  mem_write_reg;

    logic [TAG_W-1:0]      cpu_tag;
    logic                  tag_hit;
    logic                  accept;
    logic                  drain_done;
    logic [LINE_BYTES-1:0] store_mask;
    logic [LINE_BYTES-1:0] write_mask;

    line_byte_mask #(
        .LINE_BYTES (LINE_BYTES),
        .WORD_BYTES (WORD_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_store_mask (
        .address     (cpu_address),
        .byte_enable (cpu_byte_enable),
        .byte_mask   (store_mask)
    );

    assign cpu_tag    = cpu_address[ADDR_W-1:LINE_OFF];
    assign tag_hit    = (cpu_tag == tag_reg);
    // A miss in VALID is held off until the line has drained.
    assign accept     = !rst && cpu_write
                        && ((state_reg == EMPTY) || (state_reg == VALID && tag_hit));
    assign drain_done = (state_reg == DRAIN) && mem_resp;
    assign write_mask = accept ? store_mask : '0;

    assign cpu_resp      = accept;
    assign idle          = (state_reg == EMPTY);
    assign mem_write     = mem_write_reg;
    assign mem_address   = {tag_reg, {LINE_OFF{1'b0}}};
    assign mem_byte_mask = mask_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_data
            always_ff @(posedge clk) begin
                if (rst || drain_done) begin
                    data_reg[gi] <= '0;
                end else if (write_mask[gi]) begin
                    data_reg[gi] <= cpu_wdata[(gi % WORD_BYTES)*8 +: 8];
                end
            end
            assign mem_wdata[gi*8 +: 8] = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            mask_reg      <= '0;
            tag_reg       <= '0;
            mem_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (cpu_write) begin
                        tag_reg  <= cpu_tag;
                        mask_reg <= store_mask;
                        if (|cpu_byte_enable) begin
                            state_reg <= VALID;
                        end
                    end
                end
                VALID: begin
                    // A merging store beats a simultaneous flush.
                    if (cpu_write) begin
                        if (tag_hit) begin
                            mask_reg <= mask_reg | store_mask;
                        end else begin
                            state_reg     <= DRAIN;
                            mem_write_reg <= 1'b1;
                        end
                    end else if (flush) begin
                        state_reg     <= DRAIN;
                        mem_write_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_resp) begin
                        state_reg     <= EMPTY;
                        mask_reg      <= '0;
                        mem_write_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    mem_write_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef WMB_FWD_EN
    localparam int WORD_OFF = $clog2(WORD_BYTES);
    localparam int SLOTS    = LINE_BYTES / WORD_BYTES;
    localparam int SLOT_W   = LINE_OFF - WORD_OFF;

    logic [8*WORD_BYTES-1:0] slot_data [SLOTS];
    logic [WORD_BYTES-1:0]   slot_mask [SLOTS];
    logic [SLOT_W-1:0]       rd_slot;
    logic                    unused_rd;

    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_fwd
            assign slot_data[gi / WORD_BYTES][(gi % WORD_BYTES)*8 +: 8] = data_reg[gi];
            assign slot_mask[gi / WORD_BYTES][gi % WORD_BYTES]          = mask_reg[gi];
        end
    endgenerate

    assign rd_slot   = rd_address[LINE_OFF-1:WORD_OFF];
    assign unused_rd = ^rd_address;
    assign rd_hit    = (state_reg != EMPTY) && (rd_address[ADDR_W-1:LINE_OFF] == tag_reg);
    assign rd_data   = rd_hit ? slot_data[rd_slot] : '0;
    assign rd_mask   = rd_hit ? slot_mask[rd_slot] : '0;
`endif

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed self-checking bench for write_merge_buffer at default parameters.
module tb_write_merge_buffer;
    localparam int LB = 16;
    localparam int WB = 2;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cpu_write = 1'b0;
    logic [AW-1:0]   cpu_address = '0;
    logic [8*WB-1:0] cpu_wdata = '0;
    logic [WB-1:0]   cpu_byte_enable = '0;
    logic            cpu_resp;
    logic            flush = 1'b0;
    logic            idle;
    logic            mem_write;
    logic [AW-1:0]   mem_address;
    logic [8*LB-1:0] mem_wdata;
    logic [LB-1:0]   mem_byte_mask;
    logic            mem_resp = 1'b0;
`ifdef WMB_FWD_EN
    logic [AW-1:0]   rd_address = '0;
    logic            rd_hit;
    logic [8*WB-1:0] rd_data;
    logic [WB-1:0]   rd_mask;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    write_merge_buffer #(.LINE_BYTES(LB), .WORD_BYTES(WB), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_write       (cpu_write),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_byte_enable (cpu_byte_enable),
        .cpu_resp        (cpu_resp),
        .flush           (flush),
        .idle            (idle),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_mask   (mem_byte_mask),
        .mem_resp        (mem_resp)
`ifdef WMB_FWD_EN
        ,
        .rd_address      (rd_address),
        .rd_hit          (rd_hit),
        .rd_data         (rd_data),
        .rd_mask         (rd_mask)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Present a store that must be accepted; returns with cpu_write low after the edge.
    task automatic store(input string tag, input logic [AW-1:0] a, input logic [8*WB-1:0] d,
                         input logic [WB-1:0] be);
        @(negedge clk);
        cpu_write = 1'b1; cpu_address = a; cpu_wdata = d; cpu_byte_enable = be;
        #1 check({tag, ".resp"}, 128'(cpu_resp), 128'd1);
        @(posedge clk); #1;
        cpu_write = 1'b0;
    endtask

    // Flush, check the drained line stays stable, then complete it.
    task automatic flush_line(input string tag, input logic [AW-1:0] a, input logic [LB-1:0] m,
                              input logic [8*LB-1:0] d);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check({tag, ".mem_write"}, 128'(mem_write), 128'd1);
        check({tag, ".addr"}, 128'(mem_address), 128'(a));
        check({tag, ".mask"}, 128'(mem_byte_mask), 128'(m));
        check({tag, ".data"}, mem_wdata, d);
        @(posedge clk); #1;
        check({tag, ".hold"}, 128'({mem_write, mem_address, mem_byte_mask}), 128'({1'b1, a, m}));
        complete(tag);
    endtask

    task automatic complete(input string tag);
        @(negedge clk); mem_resp = 1'b1;
        @(posedge clk); #1; mem_resp = 1'b0;
        check({tag, ".done"}, 128'({mem_write, idle}), 128'b01);
        check({tag, ".cleared"}, 128'(mem_byte_mask), 128'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        check("reset.idle", 128'(idle), 128'd1);
        check("reset.mem_write", 128'(mem_write), 128'd0);
        check("reset.line", 128'({mem_address, mem_byte_mask}), 128'd0);
        check("reset.data", mem_wdata, 128'd0);

        // 1: single word in slot 1
        store("s1", 16'h0042, 16'h1234, 2'b11);
        check("s1.idle", 128'(idle), 128'd0);
        flush_line("s1", 16'h0040, 16'h000C, 128'h1234_0000);

        // 2: first and last byte; second store arrives together with flush
        store("s2a", 16'h0040, 16'h00AA, 2'b01);
        @(negedge clk);
        cpu_write = 1'b1; cpu_address = 16'h004E; cpu_wdata = 16'hBB00; cpu_byte_enable = 2'b10;
        flush = 1'b1;
        #1 check("s2b.resp", 128'(cpu_resp), 128'd1);
        @(posedge clk); #1; cpu_write = 1'b0;
        check("s2.merge_wins", 128'(mem_write), 128'd0);
        @(posedge clk); #1; flush = 1'b0;
        check("s2.flush_held", 128'(mem_write), 128'd1);
        check("s2.mask", 128'(mem_byte_mask), 128'h8001);
        check("s2.data", mem_wdata, 128'hBB00_0000_0000_0000_0000_0000_0000_00AA);
        complete("s2");

        // 3: overwrite, plus a stray mem_resp while VALID
        store("s3a", 16'h0040, 16'h1111, 2'b11);
        store("s3b", 16'h0040, 16'h2222, 2'b01);
        @(negedge clk); mem_resp = 1'b1;
        @(posedge clk); #1; mem_resp = 1'b0;
        check("s3.stray_resp", 128'({idle, mem_write}), 128'b00);
        flush_line("s3", 16'h0040, 16'h0003, 128'h1122);

        // 4: line change triggers drain, pending store accepted after mem_resp
        store("s4a", 16'h0040, 16'h5678, 2'b11);
        @(negedge clk);
        cpu_write = 1'b1; cpu_address = 16'h0050; cpu_wdata = 16'h9ABC; cpu_byte_enable = 2'b11;
        #1 check("s4.miss_resp", 128'(cpu_resp), 128'd0);
        @(posedge clk); #1;
        check("s4.mem_write", 128'(mem_write), 128'd1);
        check("s4.addr", 128'(mem_address), 128'h0040);
        check("s4.data", mem_wdata, 128'h5678);
        @(posedge clk); #1 check("s4.wait_resp1", 128'(cpu_resp), 128'd0);
        @(posedge clk); #1 check("s4.wait_resp2", 128'(cpu_resp), 128'd0);
        @(negedge clk); mem_resp = 1'b1;
        #1 check("s4.resp_cycle", 128'(cpu_resp), 128'd0);
        @(posedge clk); #1; mem_resp = 1'b0;
        check("s4.accept_after", 128'({cpu_resp, mem_write}), 128'b10);
        @(posedge clk); #1; cpu_write = 1'b0;
        check("s4.valid", 128'(idle), 128'd0);
        flush_line("s4", 16'h0050, 16'h0003, 128'h9ABC);

        // 5: reset during drain discards the line
        store("s5a", 16'h0044, 16'hCAFE, 2'b11);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("s5.drain", 128'(mem_write), 128'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("s5.after_rst", 128'({mem_write, idle}), 128'b01);
        @(negedge clk); flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 check("s5.no_drain", 128'(mem_write), 128'd0);
        end
        flush = 1'b0;
        check("s5.discarded", 128'(mem_byte_mask), 128'd0);
        store("s5b", 16'h0060, 16'hFFFF, 2'b00);
        check("s5.still_idle", 128'(idle), 128'd1);

`ifdef WMB_FWD_EN
        // 6: forwarding lookup
        store("s6a", 16'h0040, 16'h1111, 2'b11);
        @(negedge clk); rd_address = 16'h0040;
        #1 check("s6.hit0", 128'({rd_hit, rd_mask, rd_data}), 128'({1'b1, 2'b11, 16'h1111}));
        rd_address = 16'h0042;
        #1 check("s6.hit1", 128'({rd_hit, rd_mask, rd_data}), 128'({1'b1, 2'b00, 16'h0000}));
        rd_address = 16'h0050;
        #1 check("s6.miss", 128'({rd_hit, rd_mask, rd_data}), 128'd0);
        flush_line("s6", 16'h0040, 16'h0003, 128'h1111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
